// File: rtl/mlp_pkg.sv
// Shared definitions for the mlp core register map and the job sequencer FSM.
package mlp_pkg;

  localparam logic [1:0] REG_CTRL        = 2'd0;
  localparam logic [1:0] REG_IN_FIFO     = 2'd1;
  localparam logic [1:0] REG_WEIGHT_FIFO = 2'd2;
  localparam logic [1:0] REG_OUTPUT      = 2'd3;

  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_DONE_BIT  = 1;
  localparam int CTRL_LAYER_BIT = 3;

  localparam logic [31:0] CTRL_SEL_HID = 32'h0;
  localparam logic [31:0] CTRL_SEL_OUT = 32'd1 << CTRL_LAYER_BIT;
  localparam logic [31:0] CTRL_RUN     = 32'd1 << CTRL_RUN_BIT;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SEL_HID,
    ST_LD_IN,
    ST_LD_HW,
    ST_SEL_OUT,
    ST_LD_OW,
    ST_RUN,
    ST_POLL,
    ST_READ,
    ST_CAPTURE,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/mlp_job_sequencer_if.sv
// Register-port bus between the job sequencer (master) and the mlp core (slave).
interface mlp_job_sequencer_if;
  logic        mlp_write_en;
  logic [1:0]  mlp_addr;
  logic [31:0] mlp_writedata;
  logic [31:0] mlp_readdata;

  modport master (output mlp_write_en, mlp_addr, mlp_writedata, input mlp_readdata);
  modport slave  (input mlp_write_en, mlp_addr, mlp_writedata, output mlp_readdata);
endinterface

// File: rtl/mlp_stream_loader.sv
// One memory-to-FIFO stream phase: a fetch bubble on the first cycle, then one
// write per cycle while the next address is issued.
module mlp_stream_loader #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [CW-1:0] base_i,
  input  logic [CW-1:0] count_i,
  output logic [CW-1:0] mem_addr_o,
  output logic          wr_o,
  output logic          last_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  assign mem_addr_o = base_i + cnt_q;
  assign wr_o       = en_i && (cnt_q != '0);
  assign last_o     = en_i && (cnt_q == count_i);

  // Clearing on the last cycle lets two phases run back to back.
  always_comb begin
    cnt_d = '0;
    if (en_i && !last_o) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mlp_job_sequencer.sv
// Runs one complete mlp inference: loads inputs and (optionally) both weight
// layers, issues RUN, polls DONE with a timeout and captures the output.
module mlp_job_sequencer
  import mlp_pkg::*;
#(
  parameter int N_INPUTS       = 2,
  parameter int N_HIDDEN       = 4,
  parameter int N_OUTPUT       = 1,
  parameter int IN_WIDTH       = 16,
  parameter int WGT_WIDTH      = 16,
  parameter int OUT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 keep_weights,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic signed [OUT_WIDTH-1:0]          result,
  output logic [$clog2(N_INPUTS)-1:0]          in_addr,
  input  logic signed [IN_WIDTH-1:0]           in_rdata,
  output logic [$clog2(N_HIDDEN*(N_INPUTS+1)+N_OUTPUT*(N_HIDDEN+1))-1:0] w_addr,
  input  logic signed [WGT_WIDTH-1:0]          w_rdata,
  mlp_job_sequencer_if.master                  mlp
);
  localparam int HID_WORDS = N_HIDDEN * (N_INPUTS + 1);
  localparam int OUT_WORDS = N_OUTPUT * (N_HIDDEN + 1);
  localparam int I_AW      = $clog2(N_INPUTS);
  localparam int W_AW      = $clog2(HID_WORDS + OUT_WORDS);
  localparam int CW        = W_AW + 1;
  localparam int PCW       = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e                  state_q, state_d;
  logic                        keep_q, keep_d;
  logic [PCW-1:0]              poll_q, poll_d;
  logic                        error_q, error_d;
  logic signed [OUT_WIDTH-1:0] result_q, result_d;

  logic          ld_en, ld_wr, ld_last;
  logic [CW-1:0] ld_base, ld_count, ld_addr;
  logic          wr_en;
  logic [1:0]    reg_addr;
  logic [31:0]   wdata;
  logic [31:0]   in_sx, w_sx;
  logic          unused_bits;

  mlp_stream_loader #(.CW(CW)) u_loader (
    .clk        (clk),
    .rst        (rst),
    .en_i       (ld_en),
    .base_i     (ld_base),
    .count_i    (ld_count),
    .mem_addr_o (ld_addr),
    .wr_o       (ld_wr),
    .last_o     (ld_last)
  );

  assign in_sx = {{(32-IN_WIDTH){in_rdata[IN_WIDTH-1]}}, in_rdata};
  assign w_sx  = {{(32-WGT_WIDTH){w_rdata[WGT_WIDTH-1]}}, w_rdata};

  always_comb begin
    state_d  = state_q;
    keep_d   = keep_q;
    poll_d   = '0;
    error_d  = error_q;
    result_d = result_q;
    ld_en    = 1'b0;
    ld_base  = '0;
    ld_count = '0;
    wr_en    = 1'b0;
    reg_addr = REG_CTRL;
    wdata    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEL_HID;
          keep_d  = keep_weights;
          error_d = 1'b0;
        end
      end
      ST_SEL_HID: begin
        wr_en   = 1'b1;
        wdata   = CTRL_SEL_HID;
        state_d = ST_LD_IN;
      end
      ST_LD_IN: begin
        ld_en    = 1'b1;
        ld_count = CW'(N_INPUTS);
        reg_addr = REG_IN_FIFO;
        wr_en    = ld_wr;
        wdata    = ld_wr ? in_sx : '0;
        if (ld_last) state_d = keep_q ? ST_RUN : ST_LD_HW;
      end
      ST_LD_HW: begin
        ld_en    = 1'b1;
        ld_count = CW'(HID_WORDS);
        reg_addr = REG_WEIGHT_FIFO;
        wr_en    = ld_wr;
        wdata    = ld_wr ? w_sx : '0;
        if (ld_last) state_d = ST_SEL_OUT;
      end
      ST_SEL_OUT: begin
        wr_en   = 1'b1;
        wdata   = CTRL_SEL_OUT;
        state_d = ST_LD_OW;
      end
      ST_LD_OW: begin
        ld_en    = 1'b1;
        ld_base  = CW'(HID_WORDS);
        ld_count = CW'(OUT_WORDS);
        reg_addr = REG_WEIGHT_FIFO;
        wr_en    = ld_wr;
        wdata    = ld_wr ? w_sx : '0;
        if (ld_last) state_d = ST_RUN;
      end
      ST_RUN: begin
        wr_en   = 1'b1;
        wdata   = CTRL_RUN;
        state_d = ST_POLL;
      end
      ST_POLL: begin
        // First POLL cycle still shows CTRL as read before RUN landed; skip it.
        poll_d = poll_q + PCW'(1);
        if (poll_q != '0) begin
          if (mlp.mlp_readdata[CTRL_DONE_BIT]) begin
            state_d = ST_READ;
          end else if (poll_q == PCW'(TIMEOUT_CYCLES)) begin
            state_d = ST_DONE;
            error_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        reg_addr = REG_OUTPUT;
        state_d  = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        reg_addr = REG_OUTPUT;
        result_d = mlp.mlp_readdata[OUT_WIDTH-1:0];
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      keep_q   <= 1'b0;
      poll_q   <= '0;
      error_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      keep_q   <= keep_d;
      poll_q   <= poll_d;
      error_q  <= error_d;
      result_q <= result_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign error   = error_q;
  assign result  = result_q;
  assign in_addr = (state_q == ST_LD_IN) ? ld_addr[I_AW-1:0] : '0;
  assign w_addr  = (state_q == ST_LD_HW || state_q == ST_LD_OW) ? ld_addr[W_AW-1:0] : '0;

  assign mlp.mlp_write_en  = wr_en;
  assign mlp.mlp_addr      = reg_addr;
  assign mlp.mlp_writedata = wdata;

  assign unused_bits = ^{mlp.mlp_readdata[31:OUT_WIDTH], ld_addr[CW-1:W_AW]};
endmodule

// File: tb/tb_mlp_job_sequencer.sv
// Bench for mlp_job_sequencer: behavioral core stub, input/weight memories and
// a write/job scoreboard.
module tb_mlp_job_sequencer;
  import mlp_pkg::*;

  localparam int TO = 16;

  typedef int xvec_t [0:1];
  typedef int wvec_t [0:16];
  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
    int          wr_cum;
  } job_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, keep_weights;
  logic        busy, done, error;
  logic [15:0] result;
  logic [0:0]  in_addr;
  logic [4:0]  w_addr;
  logic [15:0] in_rdata, w_rdata;
  logic [15:0] in_mem [0:1];
  logic [15:0] w_mem  [0:31];

  mlp_job_sequencer_if bus ();

  mlp_job_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .keep_weights (keep_weights),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .result       (result),
    .in_addr      (in_addr),
    .in_rdata     (in_rdata),
    .w_addr       (w_addr),
    .w_rdata      (w_rdata),
    .mlp          (bus)
  );

  always_ff @(posedge clk) begin
    in_rdata <= in_mem[in_addr];
    w_rdata  <= w_mem[w_addr];
  end

  int n_checks, n_errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mlp_ref(input xvec_t x, input wvec_t w);
    int acc;
    int o;
    o = w[12];
    for (int j = 0; j < 4; j++) begin
      acc = w[3*j] + w[3*j+1] * x[0] + w[3*j+2] * x[1];
      if (acc < 0) acc = 0;
      o += w[13+j] * (acc >>> 4);
    end
    return o[15:0];
  endfunction

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Core stub: FIFOs route by LAYER_SEL, DONE rises a fixed time after RUN.
  xvec_t       cx;
  wvec_t       cw;
  int          in_idx, hw_idx, ow_idx, run_cnt;
  logic        layer_sel, done_flag;
  logic [15:0] out_reg;
  logic [31:0] rd;
  bit          never_done;
  logic [31:0] wd;
  assign wd = bus.mlp_writedata;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx <= 0; hw_idx <= 0; ow_idx <= 0; run_cnt <= 0;
      layer_sel <= 1'b0; done_flag <= 1'b0; out_reg <= '0;
    end else begin
      if (run_cnt != 0) begin
        run_cnt <= run_cnt - 1;
        if (run_cnt == 1) begin
          out_reg   <= mlp_ref(cx, cw);
          done_flag <= !never_done;
        end
      end
      if (bus.mlp_write_en) begin
        case (bus.mlp_addr)
          REG_CTRL: begin
            layer_sel <= wd[CTRL_LAYER_BIT];
            if (wd[CTRL_RUN_BIT]) begin
              run_cnt   <= 5;
              done_flag <= 1'b0;
            end
            if (!wd[CTRL_LAYER_BIT] && !wd[CTRL_RUN_BIT]) begin
              in_idx <= 0;
              hw_idx <= 0;
            end
            if (wd[CTRL_LAYER_BIT]) ow_idx <= 0;
          end
          REG_IN_FIFO: begin
            cx[in_idx % 2] <= int'($signed(wd));
            in_idx <= in_idx + 1;
          end
          REG_WEIGHT_FIFO: begin
            if (layer_sel) begin
              cw[12 + (ow_idx % 5)] <= int'($signed(wd));
              ow_idx <= ow_idx + 1;
            end else begin
              cw[hw_idx % 12] <= int'($signed(wd));
              hw_idx <= hw_idx + 1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd <= '0;
    else begin
      case (bus.mlp_addr)
        REG_CTRL:   rd <= {28'd0, layer_sel, 1'b0, done_flag, 1'b0};
        REG_OUTPUT: rd <= {{16{out_reg[15]}}, out_reg};
        default:    rd <= '0;
      endcase
    end
  end
  assign bus.mlp_readdata = rd;

  logic [33:0] exp_wr [$];
  job_t        exp_job [$];
  job_t        mj;
  wvec_t       ld_w;
  int          wr_seen, wr_pushed, cyc;
  logic [15:0] last_res;

  always @(negedge clk) begin
    if (rst || !busy) cyc = 0;
    else              cyc++;
    if (bus.mlp_write_en) begin
      wr_seen++;
      check_eq("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
      if (exp_wr.size() != 0)
        check_eq("wr_addr_data", 64'({bus.mlp_addr, bus.mlp_writedata}), 64'(exp_wr.pop_front()));
    end
    if (done) begin
      check_eq("done_expected", 64'(exp_job.size() != 0), 64'd1);
      if (exp_job.size() != 0) begin
        mj = exp_job.pop_front();
        check_eq("result", 64'(result), 64'(mj.res));
        check_eq("error", 64'(error), 64'(mj.err));
        check_eq("latency", 64'(cyc), 64'(mj.lat));
        check_eq("write_count", 64'(wr_seen), 64'(mj.wr_cum));
      end
    end
  end

  task automatic push_job(input bit k, input bit tmo);
    xvec_t x;
    job_t  j;
    exp_wr.push_back({REG_CTRL, CTRL_SEL_HID});
    for (int i = 0; i < 2; i++) begin
      exp_wr.push_back({REG_IN_FIFO, sx(in_mem[i])});
      x[i] = int'($signed(in_mem[i]));
    end
    if (!k) begin
      for (int i = 0; i < 17; i++) begin
        if (i == 12) exp_wr.push_back({REG_CTRL, CTRL_SEL_OUT});
        exp_wr.push_back({REG_WEIGHT_FIFO, sx(w_mem[i])});
        ld_w[i] = int'($signed(w_mem[i]));
      end
    end
    exp_wr.push_back({REG_CTRL, CTRL_RUN});
    wr_pushed += k ? 4 : 22;
    if (!tmo) last_res = mlp_ref(x, ld_w);
    j.res    = last_res;
    j.err    = tmo;
    j.lat    = tmo ? (k ? 7 + TO : 27 + TO) : (k ? 15 : 35);
    j.wr_cum = wr_pushed;
    exp_job.push_back(j);
  endtask

  task automatic start_job(input bit k, input int glitch);
    @(negedge clk);
    start = 1'b1; keep_weights = k;
    @(negedge clk);
    start = 1'b0; keep_weights = 1'b0;
    if (glitch > 1) begin
      repeat (glitch - 1) @(negedge clk);
      start = 1'b1; keep_weights = 1'b1;
      @(negedge clk);
      start = 1'b0; keep_weights = 1'b0;
    end
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (done) begin
        n = i;
        break;
      end
    end
    if (n == 0) check_eq("done_within_bound", 64'(done), 64'd1);
  endtask

  int n;
  logic [15:0] hw_tab [0:16] = '{16'd16, 16'd3, 16'hFFFE, 16'hFFE0, 16'd5, 16'd4,
                                 16'd100, 16'hFF80, 16'd7, 16'd48, 16'hFFFF, 16'd2,
                                 16'hFFFB, 16'd2, 16'hFFFD, 16'd4, 16'hFFF0};

  initial begin
    n_checks = 0; n_errors = 0; wr_seen = 0; wr_pushed = 0; last_res = '0;
    never_done = 1'b0; rst = 1'b1; start = 1'b0; keep_weights = 1'b0;
    in_mem[0] = 16'd0; in_mem[1] = 16'd0;
    for (int i = 0; i < 32; i++) w_mem[i] = (i < 17) ? hw_tab[i] : 16'd0;

    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_error", 64'(error), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_wen", 64'(bus.mlp_write_en), 64'd0);
    check_eq("rst_addr", 64'(bus.mlp_addr), 64'd0);
    check_eq("rst_in_addr", 64'(in_addr), 64'd0);
    check_eq("rst_w_addr", 64'(w_addr), 64'd0);
    rst = 1'b0;

    push_job(1'b0, 1'b0); start_job(1'b0, 0); wait_done(100, n);

    for (int i = 0; i < 17; i++) w_mem[i] = w_mem[i] ^ 16'h0055;
    in_mem[0] = 16'd7; in_mem[1] = 16'hFFFD;
    push_job(1'b1, 1'b0); start_job(1'b1, 0); wait_done(60, n);

    never_done = 1'b1;
    push_job(1'b1, 1'b1); start_job(1'b1, 0); wait_done(80, n);
    never_done = 1'b0;

    in_mem[0] = 16'd5; in_mem[1] = 16'hFFF7;
    push_job(1'b0, 1'b0); start_job(1'b0, 10); wait_done(100, n);

    push_job(1'b1, 1'b0); start_job(1'b1, 0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("poll_rst_busy", 64'(busy), 64'd0);
    check_eq("poll_rst_done", 64'(done), 64'd0);
    check_eq("poll_rst_error", 64'(error), 64'd0);
    check_eq("poll_rst_result", 64'(result), 64'd0);
    check_eq("poll_rst_wen", 64'(bus.mlp_write_en), 64'd0);
    check_eq("poll_rst_addr", 64'(bus.mlp_addr), 64'd0);
    check_eq("poll_rst_wdata", 64'(bus.mlp_writedata), 64'd0);
    check_eq("poll_rst_writes", 64'(exp_wr.size()), 64'd0);
    exp_job.delete(); exp_wr.delete(); wr_pushed = wr_seen; last_res = '0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    push_job(1'b0, 1'b0); start_job(1'b0, 0); wait_done(100, n);

    for (int i = 0; i < 3; i++) push_job(1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; keep_weights = 1'b0;
    wait_done(100, n);
    wait_done(100, n);
    check_eq("b2b_gap1", 64'(n), 64'd36);
    wait_done(100, n);
    check_eq("b2b_gap2", 64'(n), 64'd36);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("b2b_idle", 64'(busy), 64'd0);
    check_eq("b2b_jobs_left", 64'(exp_job.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
